// File: rtl/rx_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module  : rx_frame_monitor
// Purpose : Delimits voted receive frames, checks sequence-ID continuity and
//           keeps saturating frame / loss statistics.
// Rev     : 1.0
// ============================================================================
module rx_frame_monitor #(
  parameter int ID_OFFSET = 34,
  parameter int CNT_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_in,
  input  logic [7:0]           data_in,
  input  logic                 loss_in,
  input  logic                 clear,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic [7:0]           frame_id,
  output logic                 id_valid,
  output logic                 seq_err,
  output logic [CNT_WIDTH-1:0] frames_ok,
  output logic [CNT_WIDTH-1:0] frames_short,
  output logic [CNT_WIDTH-1:0] frames_missing,
  output logic [CNT_WIDTH-1:0] frames_dup,
  output logic [CNT_WIDTH-1:0] loss_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ID_IDX  = LEN_WIDTH'(ID_OFFSET);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] v,
                                                   input logic [7:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, v} + {{(CNT_WIDTH-7){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]             id_q, id_d;
  logic [7:0]             expected_q, expected_d;
  logic                   first_seen_q, first_seen_d;
  logic                   loss_q, loss_d;
  logic                   frame_done_q, frame_done_d;
  logic [LEN_WIDTH-1:0]   frame_len_q, frame_len_d;
  logic [7:0]             frame_id_q, frame_id_d;
  logic                   id_valid_q, id_valid_d;
  logic                   seq_err_q, seq_err_d;
  logic [CNT_WIDTH-1:0]   frames_ok_q, frames_ok_d;
  logic [CNT_WIDTH-1:0]   frames_short_q, frames_short_d;
  logic [CNT_WIDTH-1:0]   frames_missing_q, frames_missing_d;
  logic [CNT_WIDTH-1:0]   frames_dup_q, frames_dup_d;
  logic [CNT_WIDTH-1:0]   loss_count_q, loss_count_d;
  logic [7:0]             gap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      byte_cnt_q       <= '0;
      id_q             <= '0;
      expected_q       <= '0;
      first_seen_q     <= 1'b0;
      loss_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_len_q      <= '0;
      frame_id_q       <= '0;
      id_valid_q       <= 1'b0;
      seq_err_q        <= 1'b0;
      frames_ok_q      <= '0;
      frames_short_q   <= '0;
      frames_missing_q <= '0;
      frames_dup_q     <= '0;
      loss_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      id_q             <= id_d;
      expected_q       <= expected_d;
      first_seen_q     <= first_seen_d;
      loss_q           <= loss_d;
      frame_done_q     <= frame_done_d;
      frame_len_q      <= frame_len_d;
      frame_id_q       <= frame_id_d;
      id_valid_q       <= id_valid_d;
      seq_err_q        <= seq_err_d;
      frames_ok_q      <= frames_ok_d;
      frames_short_q   <= frames_short_d;
      frames_missing_q <= frames_missing_d;
      frames_dup_q     <= frames_dup_d;
      loss_count_q     <= loss_count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    id_d             = id_q;
    expected_d       = expected_q;
    first_seen_d     = first_seen_q;
    loss_d           = loss_in;
    frame_done_d     = 1'b0;
    frame_len_d      = frame_len_q;
    frame_id_d       = frame_id_q;
    id_valid_d       = id_valid_q;
    seq_err_d        = 1'b0;
    frames_ok_d      = frames_ok_q;
    frames_short_d   = frames_short_q;
    frames_missing_d = frames_missing_q;
    frames_dup_d     = frames_dup_q;
    loss_count_d     = loss_count_q;
    gap              = id_q - expected_q;

    case (state_q)
      ST_IDLE: begin
        if (en_in) begin
          state_d    = ST_RECV;
          byte_cnt_d = LEN_ONE;
          if (ID_IDX == '0) id_d = data_in;
        end
      end

      ST_RECV: begin
        if (en_in) begin
          byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + LEN_ONE;
          // byte_cnt_q is the 0-based index of the byte arriving now
          if (byte_cnt_q == ID_IDX) id_d = data_in;
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        frame_done_d = 1'b1;
        frame_len_d  = byte_cnt_q;
        if (byte_cnt_q <= ID_IDX) begin
          id_valid_d     = 1'b0;
          frame_id_d     = '0;
          frames_short_d = sat_inc(frames_short_q);
        end else begin
          id_valid_d = 1'b1;
          frame_id_d = id_q;
          if (!first_seen_q) begin
            first_seen_d = 1'b1;
            frames_ok_d  = sat_inc(frames_ok_q);
            expected_d   = id_q + 8'd1;
          end else if (gap == 8'd0) begin
            frames_ok_d = sat_inc(frames_ok_q);
            expected_d  = id_q + 8'd1;
          end else if (!gap[7]) begin
            seq_err_d        = 1'b1;
            frames_missing_d = sat_add(frames_missing_q, gap);
            expected_d       = id_q + 8'd1;
          end else begin
            // Backward step: a duplicate or late frame, keep waiting for the expected ID
            seq_err_d    = 1'b1;
            frames_dup_d = sat_inc(frames_dup_q);
          end
        end

        if (en_in) begin
          state_d    = ST_RECV;
          byte_cnt_d = LEN_ONE;
          if (ID_IDX == '0) id_d = data_in;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (loss_in && !loss_q) loss_count_d = sat_inc(loss_count_q);

    // Clear has priority over any increment landing on the same edge
    if (clear) begin
      frames_ok_d      = '0;
      frames_short_d   = '0;
      frames_missing_d = '0;
      frames_dup_d     = '0;
      loss_count_d     = '0;
      first_seen_d     = 1'b0;
    end
  end

  assign frame_done     = frame_done_q;
  assign frame_len      = frame_len_q;
  assign frame_id       = frame_id_q;
  assign id_valid       = id_valid_q;
  assign seq_err        = seq_err_q;
  assign frames_ok      = frames_ok_q;
  assign frames_short   = frames_short_q;
  assign frames_missing = frames_missing_q;
  assign frames_dup     = frames_dup_q;
  assign loss_count     = loss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_frame_monitor
// Purpose : Frame-level reference model, per-cycle compare, directed scenarios
//           followed by randomized traffic.
// Rev     : 1.0
// ============================================================================
module tb_rx_frame_monitor;

  localparam int     ID_OFF  = 34;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic [7:0]  data_in;
  logic        loss_in;
  logic        clear;
  logic        frame_done;
  logic [15:0] frame_len;
  logic [7:0]  frame_id;
  logic        id_valid;
  logic        seq_err;
  logic [31:0] frames_ok, frames_short, frames_missing, frames_dup, loss_count;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int seq_pulses = 0;
  bit cmp_en = 1'b0;
  bit rnd_mode = 1'b0;

  rx_frame_monitor dut (
    .clk           (clk),
    .rst           (rst_n),
    .en_in         (en_in),
    .data_in       (data_in),
    .loss_in       (loss_in),
    .clear         (clear),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .frame_id      (frame_id),
    .id_valid      (id_valid),
    .seq_err       (seq_err),
    .frames_ok     (frames_ok),
    .frames_short  (frames_short),
    .frames_missing(frames_missing),
    .frames_dup    (frames_dup),
    .loss_count    (loss_count)
  );

  always #5 clk = ~clk;

  // Reference model: collects whole frames as byte queues and applies the
  // frame rules one cycle after the run of en_in ends.
  logic [7:0] run_q[$];
  logic [7:0] pend_q[$];
  bit         m_pending, m_prev_loss, m_first;
  logic [7:0] m_expected;
  bit         m_done, m_id_valid, m_seq;
  int         m_len;
  logic [7:0] m_id;
  longint     m_ok, m_short, m_miss, m_dup, m_loss;
  int         m_gap;

  function automatic longint sat(input longint v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    m_seq  = 1'b0;
    if (!rst_n) begin
      run_q.delete();
      pend_q.delete();
      m_pending = 0; m_prev_loss = 0; m_first = 0; m_expected = 8'd0;
      m_id_valid = 0; m_len = 0; m_id = 8'd0;
      m_ok = 0; m_short = 0; m_miss = 0; m_dup = 0; m_loss = 0;
    end else begin
      if (m_pending) begin
        m_done = 1'b1;
        m_len  = pend_q.size();
        if (m_len <= ID_OFF) begin
          m_id_valid = 1'b0;
          m_id       = 8'd0;
          m_short    = sat(m_short + 1);
        end else begin
          m_id_valid = 1'b1;
          m_id       = pend_q[ID_OFF];
          if (!m_first) begin
            m_first    = 1'b1;
            m_ok       = sat(m_ok + 1);
            m_expected = m_id + 8'd1;
          end else begin
            m_gap = (int'(m_id) - int'(m_expected) + 256) % 256;
            if (m_gap == 0) begin
              m_ok       = sat(m_ok + 1);
              m_expected = m_id + 8'd1;
            end else if (m_gap < 128) begin
              m_seq      = 1'b1;
              m_miss     = sat(m_miss + m_gap);
              m_expected = m_id + 8'd1;
            end else begin
              m_seq = 1'b1;
              m_dup = sat(m_dup + 1);
            end
          end
        end
        m_pending = 1'b0;
        pend_q.delete();
      end
      if (en_in) begin
        run_q.push_back(data_in);
      end else if (run_q.size() != 0) begin
        pend_q = run_q;
        run_q.delete();
        m_pending = 1'b1;
      end
      if (loss_in && !m_prev_loss) m_loss = sat(m_loss + 1);
      m_prev_loss = loss_in;
      if (clear) begin
        m_ok = 0; m_short = 0; m_miss = 0; m_dup = 0; m_loss = 0;
        m_first = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("frame_done",     32'(frame_done),     32'(m_done));
      chk("frame_len",      32'(frame_len),      32'(m_len));
      chk("frame_id",       32'(frame_id),       32'(m_id));
      chk("id_valid",       32'(id_valid),       32'(m_id_valid));
      chk("seq_err",        32'(seq_err),        32'(m_seq));
      chk("frames_ok",      frames_ok,           32'(m_ok));
      chk("frames_short",   frames_short,        32'(m_short));
      chk("frames_missing", frames_missing,      32'(m_miss));
      chk("frames_dup",     frames_dup,          32'(m_dup));
      chk("loss_count",     loss_count,          32'(m_loss));
      if (frame_done) done_pulses++;
      if (seq_err)    seq_pulses++;
    end
  end

  task automatic drive(input bit e, input logic [7:0] d);
    @(negedge clk);
    en_in   = e;
    data_in = d;
    if (rnd_mode) begin
      if ($urandom_range(0, 5) == 0) loss_in = ~loss_in;
      clear = ($urandom_range(0, 79) == 0);
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] id);
    for (int i = 0; i < len; i++) drive(1'b1, (i == ID_OFF) ? id : 8'($urandom));
    drive(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    en_in = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int s0;
  int flen;
  logic [7:0] fid;

  initial begin
    rst_n = 1'b0; en_in = 1'b0; data_in = 8'h00; loss_in = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_frames_ok",  frames_ok,           32'd0);
    chk("reset_frame_done", 32'(frame_done),     32'd0);
    chk("reset_loss_count", loss_count,          32'd0);
    rst_n = 1'b1;

    // In-order IDs 5,6,7
    send_frame(60, 8'd5); idle(12);
    send_frame(60, 8'd6); idle(12);
    send_frame(60, 8'd7); idle(12);
    chk("t1_frames_ok",   frames_ok,        32'd3);
    chk("t1_frame_len",   32'(frame_len),   32'd60);
    chk("t1_done_pulses", 32'(done_pulses), 32'd3);
    chk("t1_seq_pulses",  32'(seq_pulses),  32'd0);

    // Forward gap 11 -> 15
    clear_pulse();
    s0 = seq_pulses;
    send_frame(60, 8'd10); idle(4);
    send_frame(60, 8'd11); idle(4);
    send_frame(60, 8'd15); idle(4);
    chk("t2_missing",  frames_missing,            32'd3);
    chk("t2_ok",       frames_ok,                 32'd2);
    chk("t2_seq",      32'(seq_pulses - s0),      32'd1);
    send_frame(60, 8'd16); idle(4);
    chk("t2_ok_after", frames_ok,                 32'd3);
    chk("t2_seq_after", 32'(seq_pulses - s0),     32'd1);

    // Duplicate and backward IDs
    clear_pulse();
    s0 = seq_pulses;
    send_frame(60, 8'd20); idle(4);
    send_frame(60, 8'd20); idle(4);
    send_frame(60, 8'd18); idle(4);
    chk("t3_dup", frames_dup,             32'd2);
    chk("t3_seq", 32'(seq_pulses - s0),   32'd2);
    send_frame(60, 8'd21); idle(4);
    chk("t3_ok",  frames_ok,              32'd2);

    // Short frame, then back-to-back wrap 0xFF -> 0x00
    clear_pulse();
    s0 = seq_pulses;
    send_frame(30, 8'h00); idle(4);
    chk("t4_short",      frames_short,      32'd1);
    chk("t4_id_valid",   32'(id_valid),     32'd0);
    chk("t4_frame_id",   32'(frame_id),     32'd0);
    chk("t4_len_short",  32'(frame_len),    32'd30);
    send_frame(60, 8'hFF);
    send_frame(60, 8'h00); idle(4);
    chk("t4_len",        32'(frame_len),    32'd60);
    chk("t4_ok",         frames_ok,         32'd2);
    chk("t4_seq",        32'(seq_pulses - s0), 32'd0);
    chk("t4_id_valid2",  32'(id_valid),     32'd1);

    // Loss edges, then clear while frame_done is high
    clear_pulse();
    for (int i = 0; i < 5; i++) begin @(negedge clk); loss_in = 1'b1; end
    for (int i = 0; i < 3; i++) begin @(negedge clk); loss_in = 1'b0; end
    @(negedge clk); loss_in = 1'b1;
    @(negedge clk); loss_in = 1'b0;
    idle(3);
    chk("t5_loss", loss_count, 32'd2);
    send_frame(60, 8'h42);
    idle(1);
    @(negedge clk);
    chk("t5_done_at_clear", 32'(frame_done), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_clr_ok",    frames_ok,      32'd0);
    chk("t5_clr_short", frames_short,   32'd0);
    chk("t5_clr_miss",  frames_missing, 32'd0);
    chk("t5_clr_dup",   frames_dup,     32'd0);
    chk("t5_clr_loss",  loss_count,     32'd0);
    s0 = seq_pulses;
    send_frame(60, 8'($urandom)); idle(4);
    chk("t5_first_ok",  frames_ok,      32'd1);
    chk("t5_first_seq", 32'(seq_pulses - s0), 32'd0);

    // Reset in the middle of a frame while en_in stays high
    s0 = done_pulses;
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst_n = 1'b0; en_in = 1'b1; data_in = 8'($urandom);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); rst_n = 1'b1; en_in = 1'b1; data_in = 8'($urandom);
    end
    drive(1'b0, 8'h00); idle(4);
    chk("t6_done_count", 32'(done_pulses - s0), 32'd1);
    chk("t6_len",        32'(frame_len),        32'd40);
    chk("t6_ok",         frames_ok,             32'd1);
    chk("t6_short",      frames_short,          32'd0);
    chk("t6_dup",        frames_dup,            32'd0);

    // Randomized traffic against the model
    rnd_mode = 1'b1;
    for (int f = 0; f < 300; f++) begin
      flen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 34)) : int'($urandom_range(35, 80));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: fid = m_expected;
        6, 7:             fid = m_expected + 8'($urandom_range(1, 6));
        8:                fid = m_expected - 8'($urandom_range(1, 4));
        default:          fid = 8'($urandom);
      endcase
      send_frame(flen, fid);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end
    rnd_mode = 1'b0;
    clear    = 1'b0;
    loss_in  = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
